// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit opcode map (unchanged from the combinational 16-bit ALU)
//   - control FSM state type used by the top level
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_ROL  = 4'h6;
   localparam logic [3:0] OP_ROR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_NOR  = 4'hB;
   localparam logic [3:0] OP_NAND = 4'hC;
   localparam logic [3:0] OP_XNOR = 4'hD;
   localparam logic [3:0] OP_GT   = 4'hE;
   localparam logic [3:0] OP_EQ   = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned multiply / divide engine, one bit per cycle.
//   MUL: shift-add over a 2*WIDTH accumulator {hi, lo}, initialised {0, operand_a}.
//   DIV: restoring division; accumulator {remainder, quotient}, initialised {0, operand_a}.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           load operands and begin (ignored while busy by construction in the top)
//   is_div          operation select captured at start (0 = MUL, 1 = DIV)
//   operand_a/b     multiplicand-multiplier / dividend-divisor
//   done            high in the cycle whose clock edge performs the final step
//   hi, lo          accumulator value after the current step (valid when done)
module seq_alu_muldiv #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic                 busy_q,  busy_d;
   logic                 div_q,   div_d;
   logic [CW-1:0]        count_q, count_d;
   logic [2*WIDTH-1:0]   acc_q,   acc_d;
   logic [WIDTH-1:0]     opb_q,   opb_d;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_sh;
   logic                 borrow;
   logic [WIDTH-1:0]     rem_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step;

   always_comb begin
      // Shift-add: add multiplicand into the high half when the current
      // multiplier bit is set, then shift the carry-extended pair right.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // Restoring step: bring the next dividend bit into the partial
      // remainder; subtract the divisor only if it fits. When it fits the
      // true difference is below the divisor, so the low WIDTH bits are exact.
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      borrow   = (rem_sh < {1'b0, opb_q});
      rem_diff = rem_sh[WIDTH-1:0] - opb_q;
      div_next = {(borrow ? rem_sh[WIDTH-1:0] : rem_diff), acc_q[WIDTH-2:0], ~borrow};

      step = div_q ? div_next : mul_next;
   end

   always_comb begin
      busy_d  = busy_q;
      div_d   = div_q;
      count_d = count_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      if (start) begin
         busy_d  = 1'b1;
         div_d   = is_div;
         count_d = CW'(WIDTH);
         acc_d   = {{WIDTH{1'b0}}, operand_a};
         opb_d   = operand_b;
      end else if (busy_q) begin
         acc_d   = step;
         count_d = count_q - 1'b1;
         if (count_q == CW'(1)) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q  <= 1'b0;
         div_q   <= 1'b0;
         count_q <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
      end else begin
         busy_q  <= busy_d;
         div_q   <= div_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
      end
   end

   // The final step's value is handed out combinationally so the top can
   // register it on the same edge that completes the iteration.
   assign done = busy_q && (count_q == CW'(1));
   assign hi   = step[2*WIDTH-1:WIDTH];
   assign lo   = step[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle unsigned ALU with valid/ready handshakes.
//   Single-cycle ops load the output registers on the accept edge; MUL/DIV run
//   in seq_alu_muldiv for WIDTH cycles; DIV by zero completes immediately.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   in_valid / in_ready      request handshake; opcode and operands sampled on accept
//   opcode, operand1/2       operation and operands (operand2[SHW-1:0] = shift amount)
//   out_valid / out_ready    result handshake; outputs hold while stalled
//   result, result_hi        low result / quotient, high product / remainder
//   flag_zero/carry/div0     result==0, carry-borrow-overflow, divide by zero
module seq_alu #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_div0
);

   import seq_alu_pkg::*;

   localparam int unsigned SHW = $clog2(WIDTH);

   state_t           state_q,      state_d;
   logic             out_valid_q,  out_valid_d;
   logic [WIDTH-1:0] result_q,     result_d;
   logic [WIDTH-1:0] result_hi_q,  result_hi_d;
   logic             flag_zero_q,  flag_zero_d;
   logic             flag_carry_q, flag_carry_d;
   logic             flag_div0_q,  flag_div0_d;

   logic             accept;
   logic             md_start, md_div, md_done;
   logic [WIDTH-1:0] md_hi, md_lo;

   logic [SHW-1:0]   amt;
   logic [SHW:0]     rev_amt;
   logic [WIDTH:0]   add_full, sub_full;
   logic [WIDTH-1:0] sc_res;
   logic             sc_carry;

   logic             ld_en, ld_carry, ld_div0;
   logic [WIDTH-1:0] ld_res, ld_hi;

   assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   seq_alu_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk       (clk),
      .reset     (reset),
      .start     (md_start),
      .is_div    (md_div),
      .operand_a (operand1),
      .operand_b (operand2),
      .done      (md_done),
      .hi        (md_hi),
      .lo        (md_lo)
   );

   // Single-cycle datapath.
   always_comb begin
      amt      = operand2[SHW-1:0];
      // Complementary shift for rotates; amt==0 gives a shift of WIDTH,
      // which yields zero and leaves operand1 passed through.
      rev_amt  = (SHW+1)'(WIDTH) - {1'b0, amt};
      add_full = {1'b0, operand1} + {1'b0, operand2};
      sub_full = {1'b0, operand1} - {1'b0, operand2};
      sc_res   = '0;
      sc_carry = 1'b0;
      case (opcode)
         OP_ADD:  begin sc_res = add_full[WIDTH-1:0]; sc_carry = add_full[WIDTH]; end
         OP_SUB:  begin sc_res = sub_full[WIDTH-1:0]; sc_carry = sub_full[WIDTH]; end
         OP_SHL:  sc_res = operand1 << amt;
         OP_SHR:  sc_res = operand1 >> amt;
         OP_ROL:  sc_res = (operand1 << amt) | (operand1 >> rev_amt);
         OP_ROR:  sc_res = (operand1 >> amt) | (operand1 << rev_amt);
         OP_AND:  sc_res = operand1 & operand2;
         OP_OR:   sc_res = operand1 | operand2;
         OP_XOR:  sc_res = operand1 ^ operand2;
         OP_NOR:  sc_res = ~(operand1 | operand2);
         OP_NAND: sc_res = ~(operand1 & operand2);
         OP_XNOR: sc_res = ~(operand1 ^ operand2);
         OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (operand1 > operand2)};
         OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
         default: ;
      endcase
   end

   // Control FSM and output-register loading.
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q && !out_ready;
      result_d     = result_q;
      result_hi_d  = result_hi_q;
      flag_zero_d  = flag_zero_q;
      flag_carry_d = flag_carry_q;
      flag_div0_d  = flag_div0_q;
      md_start     = 1'b0;
      md_div       = 1'b0;
      ld_en        = 1'b0;
      ld_res       = '0;
      ld_hi        = '0;
      ld_carry     = 1'b0;
      ld_div0      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (opcode == OP_MUL) begin
                  md_start = 1'b1;
                  state_d  = ST_MUL;
               end else if (opcode == OP_DIV) begin
                  if (operand2 == '0) begin
                     ld_en   = 1'b1;
                     ld_res  = '1;
                     ld_hi   = operand1;
                     ld_div0 = 1'b1;
                  end else begin
                     md_start = 1'b1;
                     md_div   = 1'b1;
                     state_d  = ST_DIV;
                  end
               end else begin
                  ld_en    = 1'b1;
                  ld_res   = sc_res;
                  ld_carry = sc_carry;
               end
            end
         end
         ST_MUL: begin
            if (md_done) begin
               ld_en    = 1'b1;
               ld_res   = md_lo;
               ld_hi    = md_hi;
               ld_carry = |md_hi;
               state_d  = ST_IDLE;
            end
         end
         ST_DIV: begin
            if (md_done) begin
               ld_en   = 1'b1;
               ld_res  = md_lo;
               ld_hi   = md_hi;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A new load wins over the consumer clearing out_valid.
      if (ld_en) begin
         out_valid_d  = 1'b1;
         result_d     = ld_res;
         result_hi_d  = ld_hi;
         flag_zero_d  = (ld_res == '0);
         flag_carry_d = ld_carry;
         flag_div0_d  = ld_div0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         result_hi_q  <= '0;
         flag_zero_q  <= 1'b0;
         flag_carry_q <= 1'b0;
         flag_div0_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         result_q     <= result_d;
         result_hi_q  <= result_hi_d;
         flag_zero_q  <= flag_zero_d;
         flag_carry_q <= flag_carry_d;
         flag_div0_q  <= flag_div0_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign result_hi  = result_hi_q;
   assign flag_zero  = flag_zero_q;
   assign flag_carry = flag_carry_q;
   assign flag_div0  = flag_div0_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=16).
//   A behavioural model (plain arithmetic + latency countdown) predicts every
//   output each cycle; directed cases pin literal results and latencies.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [3:0]  opcode;
   logic [15:0] operand1, operand2;
   logic        out_valid, out_ready;
   logic [15:0] result, result_hi;
   logic        flag_zero, flag_carry, flag_div0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .operand1   (operand1),
      .operand2   (operand2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .result_hi  (result_hi),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .flag_div0  (flag_div0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference semantics straight from the opcode table.
   function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [15:0] h,
                                  output logic z, output logic c, output logic d0, output int lat);
      int unsigned ua, ub, amt;
      logic [31:0] p;
      logic [15:0] t;
      ua = a; ub = b; amt = b[3:0];
      r = 16'h0; h = 16'h0; c = 1'b0; d0 = 1'b0; lat = 1;
      case (op)
         4'h0: begin p = ua + ub; r = p[15:0]; c = p[16]; end
         4'h1: begin r = a - b; c = (ua < ub); end
         4'h2: begin p = ua * ub; r = p[15:0]; h = p[31:16]; c = (h != 16'h0); lat = 17; end
         4'h3: begin
            if (ub == 0) begin r = 16'hFFFF; h = a; d0 = 1'b1; end
            else begin r = 16'(ua / ub); h = 16'(ua % ub); lat = 17; end
         end
         4'h4: r = 16'(ua << amt);
         4'h5: r = 16'(ua >> amt);
         4'h6: begin t = a; for (int k = 0; k < int'(amt); k++) t = {t[14:0], t[15]}; r = t; end
         4'h7: begin t = a; for (int k = 0; k < int'(amt); k++) t = {t[0], t[15:1]}; r = t; end
         4'h8: r = a & b;
         4'h9: r = a | b;
         4'hA: r = a ^ b;
         4'hB: r = ~(a | b);
         4'hC: r = ~(a & b);
         4'hD: r = ~(a ^ b);
         4'hE: r = (ua > ub) ? 16'd1 : 16'd0;
         default: r = (ua == ub) ? 16'd1 : 16'd0;
      endcase
      z = (r == 16'h0);
   endfunction

   // ---------------- model + per-cycle compare ----------------
   logic        m_valid, m_z, m_c, m_d;
   logic [15:0] m_r, m_h;
   logic        pend, p_z, p_c, p_d;
   logic [15:0] p_r, p_h;
   int          pcnt;
   logic        nv, acc;
   logic [15:0] e_r, e_h;
   logic        e_z, e_c, e_d;
   int          e_lat;

   initial begin
      m_valid = 0; m_r = 0; m_h = 0; m_z = 0; m_c = 0; m_d = 0;
      pend = 0; pcnt = 0; p_r = 0; p_h = 0; p_z = 0; p_c = 0; p_d = 0;
      forever begin
         @(negedge clk);
         chk("out_valid",  out_valid,  m_valid);
         chk("in_ready",   in_ready,   !pend && (!m_valid || out_ready));
         chk("result",     result,     m_r);
         chk("result_hi",  result_hi,  m_h);
         chk("flag_zero",  flag_zero,  m_z);
         chk("flag_carry", flag_carry, m_c);
         chk("flag_div0",  flag_div0,  m_d);
         #3;
         if (!reset) begin
            m_valid = 0; m_r = 0; m_h = 0; m_z = 0; m_c = 0; m_d = 0;
            pend = 0; pcnt = 0;
         end else begin
            acc = in_valid && !pend && (!m_valid || out_ready);
            nv  = m_valid && !out_ready;
            if (pend) begin
               pcnt--;
               if (pcnt == 0) begin
                  pend = 0; nv = 1;
                  m_r = p_r; m_h = p_h; m_z = p_z; m_c = p_c; m_d = p_d;
               end
            end else if (acc) begin
               ref_op(opcode, operand1, operand2, e_r, e_h, e_z, e_c, e_d, e_lat);
               if (e_lat == 1) begin
                  nv = 1;
                  m_r = e_r; m_h = e_h; m_z = e_z; m_c = e_c; m_d = e_d;
               end else begin
                  pend = 1; pcnt = e_lat - 1;
                  p_r = e_r; p_h = e_h; p_z = e_z; p_c = e_c; p_d = e_d;
               end
            end
            m_valid = nv;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [15:0] r, output logic [15:0] h,
                        output logic z, output logic c, output logic d0, output int rdy_hi);
      bit got;
      int cyc;
      in_valid = 1; opcode = op; operand1 = a; operand2 = b; out_ready = 1;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         #2;
         if (in_ready) got = 1;
         @(negedge clk); #1;
      end
      in_valid = 0;
      chk("accept", got, 1);
      cyc = 1; rdy_hi = 0;
      while (!out_valid && cyc < 40) begin
         if (in_ready) rdy_hi++;
         @(negedge clk); #1;
         cyc++;
      end
      lat = out_valid ? cyc : -1;
      r = result; h = result_hi; z = flag_zero; c = flag_carry; d0 = flag_div0;
   endtask

   task automatic run_dir(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] xr, input logic [15:0] xh, input logic xz, input logic xc,
                          input logic xd, input int xlat);
      int lat, rh;
      logic [15:0] r, h;
      logic z, c, d;
      issue(op, a, b, lat, r, h, z, c, d, rh);
      chk({nm, ".latency"}, lat, xlat);
      chk({nm, ".result"}, r, xr);
      chk({nm, ".result_hi"}, h, xh);
      chk({nm, ".zero"}, z, xz);
      chk({nm, ".carry"}, c, xc);
      chk({nm, ".div0"}, d, xd);
      chk({nm, ".busy_in_ready"}, rh, 0);
   endtask

   // ---------------- stimulus ----------------
   logic [15:0] pr, ph;
   logic        pz, pc, pd;
   int          plat;
   bit          got;

   function automatic logic [15:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'($urandom_range(0, 15));
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      reset = 0; in_valid = 0; opcode = 0; operand1 = 0; operand2 = 0; out_ready = 0;

      ref_op(4'h2, 16'hFFFF, 16'hFFFF, pr, ph, pz, pc, pd, plat);
      chk("model.mul_max.lo", pr, 16'h0001);
      chk("model.mul_max.hi", ph, 16'hFFFE);
      chk("model.mul_max.carry", pc, 1);
      chk("model.mul_max.lat", plat, 17);
      ref_op(4'h6, 16'h8001, 16'h0004, pr, ph, pz, pc, pd, plat);
      chk("model.rol", pr, 16'h0018);
      ref_op(4'h3, 16'd100, 16'd7, pr, ph, pz, pc, pd, plat);
      chk("model.div.q", pr, 16'd14);
      chk("model.div.r", ph, 16'd2);
      ref_op(4'h0, 16'hFFFF, 16'h0001, pr, ph, pz, pc, pd, plat);
      chk("model.add.zero", pz, 1);
      chk("model.add.carry", pc, 1);

      repeat (3) @(negedge clk);
      #1 reset = 1;
      @(negedge clk); #1;

      // Reset in the middle of a multiply abandons it.
      in_valid = 1; opcode = 4'h2; operand1 = 16'h1234; operand2 = 16'h5678; out_ready = 1;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         #2;
         if (in_ready) got = 1;
         @(negedge clk); #1;
      end
      chk("midmul.accept", got, 1);
      in_valid = 0;
      repeat (4) @(negedge clk);
      #1 reset = 0;
      repeat (2) @(negedge clk);
      #1 reset = 1;
      @(negedge clk);
      chk("midmul.out_valid", out_valid, 0);
      chk("midmul.in_ready", in_ready, 1);
      chk("midmul.result", result, 16'h0000);
      chk("midmul.result_hi", result_hi, 16'h0000);
      chk("midmul.flags", {flag_zero, flag_carry, flag_div0}, 3'b000);
      #1;
      repeat (20) @(negedge clk);
      #1;

      run_dir("add_max",  4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 1, 0, 1);
      run_dir("sub_0m1",  4'h1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 0, 1, 0, 1);
      run_dir("mul_max",  4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 1, 0, 17);
      run_dir("mul_zero", 4'h2, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1, 0, 0, 17);
      run_dir("div_100_7",4'h3, 16'd100,  16'd7,    16'd14,   16'd2,    0, 0, 0, 17);
      run_dir("div_zero", 4'h3, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 0, 0, 1, 1);
      run_dir("rol",      4'h6, 16'h8001, 16'h0004, 16'h0018, 16'h0000, 0, 0, 0, 1);
      run_dir("shr",      4'h5, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 0, 0, 0, 1);
      run_dir("ror0",     4'h7, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 0, 0, 0, 1);
      run_dir("gt_false", 4'hE, 16'h0003, 16'h0007, 16'h0000, 16'h0000, 1, 0, 0, 1);

      // Backpressure: XOR result held for 5 cycles while another request waits.
      in_valid = 1; opcode = 4'hA; operand1 = 16'hF0F0; operand2 = 16'h0FF0; out_ready = 1;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         #2;
         if (in_ready) got = 1;
         @(negedge clk); #1;
      end
      chk("bp.accept", got, 1);
      out_ready = 0; in_valid = 1; opcode = 4'h8; operand1 = 16'h1111; operand2 = 16'h2222;
      for (int k = 0; k < 5; k++) begin
         #2;
         chk("bp.out_valid", out_valid, 1);
         chk("bp.result", result, 16'hFF00);
         chk("bp.in_ready", in_ready, 0);
         @(negedge clk); #1;
      end
      opcode = 4'hF; operand1 = 16'd5; operand2 = 16'd5; out_ready = 1;
      #2;
      chk("bp.same_cycle_ready", in_ready, 1);
      @(negedge clk); #1;
      in_valid = 0;
      chk("bp.eq.out_valid", out_valid, 1);
      chk("bp.eq.result", result, 16'h0001);
      chk("bp.eq.zero", flag_zero, 0);

      // Randomised traffic; the per-cycle model checks everything.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk); #1;
         reset     = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         in_valid  = $urandom_range(0, 1) == 1;
         opcode    = 4'($urandom_range(0, 15));
         operand1  = rnd_operand();
         operand2  = rnd_operand();
         out_ready = $urandom_range(0, 3) != 0;
      end
      @(negedge clk); #1;
      reset = 1; in_valid = 0; out_ready = 1;
      repeat (40) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
